// File: rtl/uart_pb_periph.sv
// uart_pb_periph
// Picoblaze port-mapped 8N1 UART: programmable 16x oversample baud tick,
// TX/RX FIFOs, status register, interrupt-enable register, level interrupt.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   port_id, out_port   cpu address / write data
//   write_strobe        cpu write qualifier
//   read_strobe         cpu read qualifier
//   in_port             registered read data to cpu (1-cycle latency)
//   interrupt           registered level interrupt
//   RX                  asynchronous serial input
//   TX                  serial output, idle high
// Register map (offset from BASE_ADDR):
//   +0 DATA   write: push TX FIFO, read: pop RX FIFO
//   +1 STATUS {0, tx_busy, frame_err, overrun, tx_full, tx_empty, rx_full, rx_not_empty}
//   +2 IRQ_EN {00000, error, tx_empty, rx_data}
module uart_pb_periph #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         BAUD_DIV  = 27,
  parameter int         DATA_BITS = 8,
  parameter int         FIFO_AW   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       RX,
  output logic       TX
);

  localparam logic [7:0]  A_DATA    = BASE_ADDR;
  localparam logic [7:0]  A_STAT    = BASE_ADDR + 8'd1;
  localparam logic [7:0]  A_IRQ     = BASE_ADDR + 8'd2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam int          BW        = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam int          CW        = FIFO_AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // cpu bus decode
  logic w_sel_data, w_sel_stat, w_sel_irq;
  logic w_rx_pop, w_tx_push, w_stat_rd, w_tx_pop;
  assign w_sel_data = (port_id == A_DATA);
  assign w_sel_stat = (port_id == A_STAT);
  assign w_sel_irq  = (port_id == A_IRQ);
  assign w_rx_pop   = read_strobe & w_sel_data;
  assign w_tx_push  = write_strobe & w_sel_data;
  assign w_stat_rd  = read_strobe & w_sel_stat;

  // baud tick generator
  logic [15:0] r_baud_cnt;
  logic        w_tick;
  assign w_tick = (r_baud_cnt == BAUD_LAST);
  always_ff @(posedge clk) begin
    if (reset)       r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + 16'd1;
  end

  // FIFOs: index 0 = RX, 1 = TX. Head is visible combinationally.
  logic [1:0]           w_f_push, w_f_pop, w_f_empty, w_f_full;
  logic [DATA_BITS-1:0] w_f_din  [2];
  logic [DATA_BITS-1:0] w_f_dout [2];
  logic                 r_rx_push;
  logic [DATA_BITS-1:0] r_rx_sh;

  assign w_f_push[0] = r_rx_push;
  assign w_f_din[0]  = r_rx_sh;
  assign w_f_pop[0]  = w_rx_pop;
  assign w_f_push[1] = w_tx_push;
  assign w_f_din[1]  = out_port[DATA_BITS-1:0];
  assign w_f_pop[1]  = w_tx_pop;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]        r_cnt;
    logic                 w_do_push, w_do_pop;
    // A push into a full FIFO still lands if a pop frees a slot that cycle.
    assign w_do_pop     = w_f_pop[g] & ~w_f_empty[g];
    assign w_do_push    = w_f_push[g] & (~w_f_full[g] | w_do_pop);
    assign w_f_empty[g] = (r_cnt == '0);
    assign w_f_full[g]  = r_cnt[FIFO_AW];
    assign w_f_dout[g]  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= w_f_din[g];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_do_push) r_wptr <= r_wptr + FIFO_AW'(1);
        if (w_do_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
        case ({w_do_push, w_do_pop})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // RX synchroniser; third flop gives the falling-edge detector
  logic r_rx_s1, r_rx_s2, r_rx_s3;
  logic w_rx, w_rx_fall;
  assign w_rx      = r_rx_s2;
  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // RX FSM: start bit checked at tick 8 (mid-bit), then every 16 ticks
  state_t          r_rx_st;
  logic [3:0]      r_rx_tcnt;
  logic [BW-1:0]   r_rx_bit;
  logic            r_rx_ferr_set;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_st       <= ST_IDLE;
      r_rx_tcnt     <= '0;
      r_rx_bit      <= '0;
      r_rx_push     <= 1'b0;
      r_rx_ferr_set <= 1'b0;
    end else begin
      r_rx_push     <= 1'b0;
      r_rx_ferr_set <= 1'b0;
      case (r_rx_st)
        ST_IDLE: if (w_rx_fall) begin
          r_rx_st   <= ST_START;
          r_rx_tcnt <= '0;
        end
        ST_START: if (w_tick) begin
          if (r_rx_tcnt == 4'd7) begin
            r_rx_st   <= w_rx ? ST_IDLE : ST_DATA;  // high again: glitch
            r_rx_tcnt <= '0;
            r_rx_bit  <= '0;
          end else begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
          end
        end
        ST_DATA: if (w_tick) begin
          r_rx_tcnt <= r_rx_tcnt + 4'd1;
          if (r_rx_tcnt == 4'd15) begin
            r_rx_sh <= {w_rx, r_rx_sh[DATA_BITS-1:1]};
            if (r_rx_bit == LAST_BIT) r_rx_st  <= ST_STOP;
            else                      r_rx_bit <= r_rx_bit + BW'(1);
          end
        end
        ST_STOP: if (w_tick) begin
          r_rx_tcnt <= r_rx_tcnt + 4'd1;
          if (r_rx_tcnt == 4'd15) begin
            r_rx_push     <= w_rx;
            r_rx_ferr_set <= ~w_rx;
            r_rx_st       <= ST_IDLE;
          end
        end
        default: r_rx_st <= ST_IDLE;
      endcase
    end
  end

  // TX FSM: FIFO popped on entry to START, including straight out of STOP
  state_t               r_tx_st;
  logic [3:0]           r_tx_tcnt;
  logic [BW-1:0]        r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_sh;
  logic                 r_tx;
  assign w_tx_pop = w_tick & ~w_f_empty[1] &
                    ((r_tx_st == ST_IDLE) | ((r_tx_st == ST_STOP) & (r_tx_tcnt == 4'd15)));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_st   <= ST_IDLE;
      r_tx_tcnt <= '0;
      r_tx_bit  <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_tx_st)
        ST_IDLE: if (w_tx_pop) begin
          r_tx_st   <= ST_START;
          r_tx_tcnt <= '0;
          r_tx_sh   <= w_f_dout[1];
          r_tx      <= 1'b0;
        end
        ST_START: if (w_tick) begin
          r_tx_tcnt <= r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) begin
            r_tx_st  <= ST_DATA;
            r_tx_bit <= '0;
            r_tx     <= r_tx_sh[0];
          end
        end
        ST_DATA: if (w_tick) begin
          r_tx_tcnt <= r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) begin
            if (r_tx_bit == LAST_BIT) begin
              r_tx_st <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + BW'(1);
              r_tx_sh  <= {1'b0, r_tx_sh[DATA_BITS-1:1]};
              r_tx     <= r_tx_sh[1];
            end
          end
        end
        ST_STOP: if (w_tick) begin
          r_tx_tcnt <= r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) begin
            if (w_tx_pop) begin
              r_tx_st <= ST_START;
              r_tx_sh <= w_f_dout[1];
              r_tx    <= 1'b0;
            end else begin
              r_tx_st <= ST_IDLE;
            end
          end
        end
        default: r_tx_st <= ST_IDLE;
      endcase
    end
  end

  // registers, read mux, interrupt
  logic [2:0] r_irq_en;
  logic       r_ovr, r_ferr, r_irq;
  logic [7:0] r_in_port;
  logic       w_tx_busy, w_ovr_set;
  logic [7:0] w_status, w_rx_ext;

  assign w_tx_busy = (r_tx_st != ST_IDLE);
  assign w_ovr_set = r_rx_push & w_f_full[0] & ~w_rx_pop;
  assign w_status  = {1'b0, w_tx_busy, r_ferr, r_ovr,
                      w_f_full[1], w_f_empty[1], w_f_full[0], ~w_f_empty[0]};

  always_comb begin
    w_rx_ext = '0;
    if (!w_f_empty[0]) w_rx_ext[DATA_BITS-1:0] = w_f_dout[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en  <= '0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
      r_irq     <= 1'b0;
      r_in_port <= '0;
    end else begin
      if (write_strobe & w_sel_irq) r_irq_en <= out_port[2:0];
      // sticky flags: a new event beats the clear-on-read
      if (w_ovr_set)      r_ovr  <= 1'b1;
      else if (w_stat_rd) r_ovr  <= 1'b0;
      if (r_rx_ferr_set)  r_ferr <= 1'b1;
      else if (w_stat_rd) r_ferr <= 1'b0;
      if (w_sel_data)      r_in_port <= w_rx_ext;
      else if (w_sel_stat) r_in_port <= w_status;
      else if (w_sel_irq)  r_in_port <= {5'b0, r_irq_en};
      else                 r_in_port <= '0;
      r_irq <= (r_irq_en[0] & ~w_f_empty[0]) |
               (r_irq_en[1] & w_f_empty[1] & ~w_tx_busy) |
               (r_irq_en[2] & (r_ovr | r_ferr));
    end
  end

  assign in_port   = r_in_port;
  assign interrupt = r_irq;
  assign TX        = r_tx;

endmodule

// File: tb/tb_uart_pb_periph.sv
// Bench for uart_pb_periph at BAUD_DIV=4 (64 clk per bit), 8 data bits,
// 16-entry FIFOs, registers based at 0x20. A queue-based model tracks the RX
// FIFO contents, sticky flags and interrupt enables.
module tb_uart_pb_periph;
  localparam logic [7:0] BASE  = 8'h20;
  localparam int         BAUD  = 4;
  localparam int         DEPTH = 16;
  localparam int         BITC  = 16 * BAUD;
  localparam int         FRAME = 10 * BITC;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id, out_port;
  logic       write_strobe, read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       RX;
  logic       TX;

  uart_pb_periph #(.BASE_ADDR(BASE), .BAUD_DIV(BAUD), .DATA_BITS(8), .FIFO_AW(4)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
    .interrupt(interrupt), .RX(RX), .TX(TX)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [7:0] m_rxq [$];
  bit         m_ovr, m_fe;
  logic [2:0] m_en;

  function automatic logic [7:0] m_status(input bit busy, input int tx_pending);
    return {1'b0, busy, m_fe, m_ovr, 1'b0, (tx_pending == 0),
            (m_rxq.size() == DEPTH), (m_rxq.size() != 0)};
  endfunction

  // evaluated only with the transmitter idle and its FIFO empty
  function automatic logic m_irq();
    return (m_en[0] & (m_rxq.size() != 0)) | m_en[1] | (m_en[2] & (m_ovr | m_fe));
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    port_id = addr; out_port = data; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    port_id = addr; read_strobe = 1'b1;
    @(negedge clk);
    data = in_port;
    read_strobe = 1'b0;
  endtask

  task automatic read_data_chk(input string tag);
    logic [7:0] d, e;
    cpu_read(BASE, d);
    e = (m_rxq.size() != 0) ? m_rxq.pop_front() : 8'h00;
    check_val(tag, d, e);
  endtask

  task automatic read_stat_chk(input string tag);
    logic [7:0] d;
    cpu_read(BASE + 8'd1, d);
    check_val(tag, d, m_status(1'b0, 0));
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic check_irq(input string tag);
    repeat (2) @(negedge clk);
    check_val(tag, 8'(interrupt), 8'(m_irq()));
  endtask

  task automatic set_en(input logic [7:0] v);
    cpu_write(BASE + 8'd2, v);
    m_en = v[2:0];
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop);
    RX = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BITC) @(negedge clk);
    end
    RX = stop;
    repeat (BITC) @(negedge clk);
    RX = 1'b1;
    repeat (32) @(negedge clk);
    if (!stop) m_fe = 1'b1;
    else if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // Writes n bytes and checks every bit cell of the resulting back-to-back
  // frames near both ends of the cell, plus STATUS partway through frame 0.
  task automatic tx_frames(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    logic [7:0] bytes [3];
    int w;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    fork
      begin
        for (int i = 0; i < n; i++) cpu_write(BASE, bytes[i]);
      end
      begin
        w = 0;
        while (TX !== 1'b0 && w < 100) begin
          @(negedge clk);
          w++;
        end
        if (w >= 100) check_val("tx_start_timeout", 8'(TX), 8'h00);
        else begin
          for (int c = 0; c < n * FRAME; c++) begin
            int f, slot, pos;
            logic e;
            f    = c / FRAME;
            slot = (c % FRAME) / BITC;
            pos  = (c % FRAME) % BITC;
            if (pos == 2 || pos == BITC - 3) begin
              if (slot == 0)      e = 1'b0;
              else if (slot == 9) e = 1'b1;
              else                e = bytes[f][slot-1];
              check_val($sformatf("tx_f%0d_slot%0d_pos%0d", f, slot, pos), 8'(TX), 8'(e));
            end
            if (c == 100) begin
              port_id = BASE + 8'd1;
              read_strobe = 1'b1;
            end
            if (c == 101) begin
              check_val("tx_busy_status", in_port, m_status(1'b1, n - 1));
              read_strobe = 1'b0;
              m_ovr = 1'b0;
              m_fe  = 1'b0;
            end
            @(negedge clk);
          end
        end
      end
    join
    repeat (2) @(negedge clk);
    check_val("tx_idle_line", 8'(TX), 8'h01);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, v;
    int act;
    reset = 1'b1; RX = 1'b1; port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0;
    m_ovr = 1'b0; m_fe = 1'b0; m_en = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_in_port", in_port, 8'h00);
    check_val("rst_tx", 8'(TX), 8'h01);
    check_val("rst_irq", 8'(interrupt), 8'h00);
    read_stat_chk("rst_status");

    // register access and decode
    set_en(8'hFF);
    cpu_read(BASE + 8'd2, d);
    check_val("irq_en_readback", d, 8'h07);
    check_irq("irq_tx_empty_en");
    set_en(8'h00);
    check_irq("irq_all_disabled");
    cpu_write(BASE + 8'd3, 8'hFF);
    cpu_read(BASE + 8'd3, d);
    check_val("unmapped_read", d, 8'h00);
    read_data_chk("empty_data_read");
    read_stat_chk("status_after_empty_read");

    // directed transmit
    tx_frames(1, 8'h55, 8'h00, 8'h00);
    read_stat_chk("status_after_tx");

    // directed receive with rx interrupt
    set_en(8'h01);
    rx_frame(8'hA3, 1'b1);
    check_irq("irq_rx_data");
    read_data_chk("rx_a3");
    check_irq("irq_rx_drained");
    read_stat_chk("status_after_rx_pop");

    // overrun: 17 frames, no reads
    set_en(8'h00);
    for (int i = 0; i < DEPTH + 1; i++) rx_frame(8'($urandom), 1'b1);
    read_stat_chk("status_overrun_full");
    for (int i = 0; i < DEPTH; i++) read_data_chk($sformatf("rx_fifo_%0d", i));
    read_stat_chk("status_after_drain");

    // framing error
    set_en(8'h04);
    rx_frame(8'($urandom), 1'b0);
    check_irq("irq_frame_err");
    read_data_chk("frame_err_no_data");
    read_stat_chk("status_frame_err");
    check_irq("irq_err_cleared");

    // short start pulse is rejected
    RX = 1'b0;
    repeat (5 * BAUD) @(negedge clk);
    RX = 1'b1;
    repeat (FRAME) @(negedge clk);
    read_stat_chk("status_after_glitch");
    read_data_chk("glitch_no_data");

    // randomized traffic
    for (int it = 0; it < 8; it++) begin
      v = 8'($urandom);
      set_en(v);
      act = $urandom_range(0, 3);
      case (act)
        0, 1: rx_frame(8'($urandom), ($urandom_range(0, 4) != 0));
        2:    tx_frames($urandom_range(1, 3), 8'($urandom), 8'($urandom), 8'($urandom));
        default: read_data_chk($sformatf("rand_read_%0d", it));
      endcase
      check_irq($sformatf("rand_irq_%0d", it));
      if ($urandom_range(0, 1) == 1) read_stat_chk($sformatf("rand_status_%0d", it));
    end
    while (m_rxq.size() != 0) read_data_chk("final_drain");

    // reset in the middle of a transmit frame
    cpu_write(BASE, 8'hC3);
    repeat (200) @(negedge clk);
    check_val("tx_active_before_reset", 8'(TX), 8'h00);
    reset = 1'b1;
    @(negedge clk);
    check_val("tx_high_after_reset", 8'(TX), 8'h01);
    check_val("irq_low_after_reset", 8'(interrupt), 8'h00);
    reset = 1'b0;
    m_rxq.delete();
    m_ovr = 1'b0; m_fe = 1'b0; m_en = 3'b000;
    read_stat_chk("status_after_mid_reset");
    repeat (FRAME) @(negedge clk);
    check_val("tx_stays_idle", 8'(TX), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
